// File: rtl/boot_run_ctrl_pkg.sv
// Shared types and constants for the boot/run controller: state encoding and stream framing.
package boot_run_ctrl_pkg;

    localparam int unsigned BOOT_HDR_BYTES = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        LOAD,
        RUN,
        HALTED,
        ERROR
    } boot_state_t;

endpackage

// File: rtl/boot_run_ctrl_word_packer.sv
// Little-endian byte-to-word assembler; emits a one-cycle registered word_valid when byte 3 lands.
module word_packer
    import boot_run_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              word_valid_o,
    output logic [WORD_W-1:0] word_o
);

    localparam int unsigned BIDX_W = $clog2(BYTES_PER_WORD);
    localparam int unsigned PART_W = WORD_W - 8;

    logic [BIDX_W-1:0] byte_idx_q;
    logic [PART_W-1:0] part_q;
    logic              word_valid_q;
    logic [WORD_W-1:0] word_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx_q   <= '0;
            part_q       <= '0;
            word_valid_q <= 1'b0;
            word_q       <= '0;
        end else begin
            word_valid_q <= 1'b0;
            if (clr_i) begin
                byte_idx_q <= '0;
            end else if (byte_valid_i) begin
                if (byte_idx_q == BIDX_W'(BYTES_PER_WORD - 1)) begin
                    word_q       <= {byte_i, part_q};
                    word_valid_q <= 1'b1;
                    byte_idx_q   <= '0;
                end else begin
                    part_q[8*byte_idx_q +: 8] <= byte_i;
                    byte_idx_q                <= byte_idx_q + BIDX_W'(1);
                end
            end
        end
    end

    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/boot_run_ctrl.sv
// Core life-cycle sequencer: receives a framed program into instruction memory, then releases
// the core from reset and counts run cycles until it halts.
module boot_run_ctrl
    import boot_run_ctrl_pkg::*;
#(
    parameter int unsigned MEM_SIZE_INST = 1024,
    parameter int unsigned CNT_WIDTH     = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             rx_valid_i,
    input  logic [7:0]                       rx_data_i,
    output logic                             rx_ready_o,
    output logic                             imem_we_o,
    output logic [$clog2(MEM_SIZE_INST)-1:0] imem_addr_o,
    output logic [31:0]                      imem_wdata_o,
    output logic                             core_rst_n_o,
    input  logic                             core_halt_i,
    input  logic                             reload_i,
    output logic                             done_o,
    output logic                             err_o,
    output logic [CNT_WIDTH-1:0]             run_cycles_o
);

    localparam int unsigned AW     = $clog2(MEM_SIZE_INST);
    localparam int unsigned WIDX_W = AW + 1;

    boot_state_t          state_q;
    logic [15:0]          n_q;
    logic [WIDX_W-1:0]    widx_q;
    logic [AW-1:0]        addr_q;
    logic                 rx_ready_q;
    logic                 core_rst_n_q;
    logic                 done_q;
    logic                 err_q;
    logic [CNT_WIDTH-1:0] run_cycles_q;

    logic        accept_c;
    logic        load_byte_c;
    logic        word_valid;
    logic [15:0] n_full_c;
    logic        hdr_bad_c;
    logic        all_written_c;

    assign accept_c      = rx_valid_i & rx_ready_q & ~reload_i;
    assign load_byte_c   = accept_c & (state_q == LOAD);
    assign n_full_c      = {rx_data_i, n_q[7:0]};
    assign hdr_bad_c     = (n_full_c == 16'd0) || (32'(n_full_c) > MEM_SIZE_INST);
    assign all_written_c = (widx_q == WIDX_W'(n_q));

    word_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (reload_i),
        .byte_valid_i (load_byte_c),
        .byte_i       (rx_data_i),
        .word_valid_o (word_valid),
        .word_o       (imem_wdata_o)
    );

    // The packer's registered pulse is the write strobe; the address is captured on the same edge.
    assign imem_we_o = word_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= HDR0;
            n_q          <= '0;
            widx_q       <= '0;
            addr_q       <= '0;
            rx_ready_q   <= 1'b0;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            run_cycles_q <= '0;
        end else if (reload_i) begin
            state_q      <= HDR0;
            n_q          <= '0;
            widx_q       <= '0;
            rx_ready_q   <= 1'b1;
            core_rst_n_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            run_cycles_q <= '0;
        end else begin
            case (state_q)
                HDR0: begin
                    rx_ready_q <= 1'b1;
                    if (accept_c) begin
                        n_q[7:0] <= rx_data_i;
                        state_q  <= HDR1;
                    end
                end
                HDR1: begin
                    if (accept_c) begin
                        n_q    <= n_full_c;
                        widx_q <= '0;
                        if (hdr_bad_c) begin
                            state_q    <= ERROR;
                            rx_ready_q <= 1'b0;
                            err_q      <= 1'b1;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    // Release the core one cycle after the final write pulse.
                    if (all_written_c) begin
                        state_q      <= RUN;
                        core_rst_n_q <= 1'b1;
                    end else if (load_byte_c && (u_packer.byte_idx_q == 2'd3)) begin
                        addr_q <= widx_q[AW-1:0];
                        widx_q <= widx_q + WIDX_W'(1);
                        if ((widx_q + WIDX_W'(1)) == WIDX_W'(n_q)) begin
                            rx_ready_q <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (run_cycles_q != {CNT_WIDTH{1'b1}}) begin
                        run_cycles_q <= run_cycles_q + CNT_WIDTH'(1);
                    end
                    if (core_halt_i) begin
                        state_q      <= HALTED;
                        core_rst_n_q <= 1'b0;
                        done_q       <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rx_ready_o   = rx_ready_q;
    assign imem_addr_o  = addr_q;
    assign core_rst_n_o = core_rst_n_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign run_cycles_o = run_cycles_q;

endmodule

// File: tb/tb_boot_run_ctrl.sv
// Scoreboard bench for boot_run_ctrl: expected memory writes are queued by the stimulus and
// checked by an independent monitor; status outputs are checked directly at fixed points.
module tb_boot_run_ctrl;

    localparam int unsigned MEM = 1024;
    localparam int unsigned CW  = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_data_i = '0;
    logic        rx_ready_o;
    logic        imem_we_o;
    logic [9:0]  imem_addr_o;
    logic [31:0] imem_wdata_o;
    logic        core_rst_n_o;
    logic        core_halt_i = 1'b0;
    logic        reload_i = 1'b0;
    logic        done_o;
    logic        err_o;
    logic [31:0] run_cycles_o;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t sb_q[$];

    boot_run_ctrl #(.MEM_SIZE_INST(MEM), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid_i   (rx_valid_i),
        .rx_data_i    (rx_data_i),
        .rx_ready_o   (rx_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_wdata_o (imem_wdata_o),
        .core_rst_n_o (core_rst_n_o),
        .core_halt_i  (core_halt_i),
        .reload_i     (reload_i),
        .done_o       (done_o),
        .err_o        (err_o),
        .run_cycles_o (run_cycles_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst && imem_we_o) begin
            wr_t e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h, none expected",
                         imem_addr_o, imem_wdata_o);
            end else begin
                e = sb_q.pop_front();
                if (imem_addr_o !== e.addr || imem_wdata_o !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr %0d data 0x%08h expected addr %0d data 0x%08h",
                             imem_addr_o, imem_wdata_o, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        int   n;
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        n = 0;
        do begin
            acc = rx_ready_o;
            tick();
            n++;
        end while (!acc && n < 100);
        rx_valid_i = 1'b0;
        if (!acc) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: byte 0x%02h not accepted", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (gap) tick();
        end
    endtask

    task automatic do_reload();
        reload_i = 1'b1;
        tick();
        reload_i = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        // reset values
        #12;
        check("rst_ready", 32'(rx_ready_o), 0);
        check("rst_we", 32'(imem_we_o), 0);
        check("rst_core", 32'(core_rst_n_o), 0);
        check("rst_done_err", {30'd0, done_o, err_o}, 0);
        check("rst_cycles", run_cycles_o, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("hdr0_ready", 32'(rx_ready_o), 1);

        // N=2 load, core release timing, then halt on 10th RUN cycle
        sb_q.push_back('{10'd0, 32'h0050_0093});
        sb_q.push_back('{10'd1, 32'h0000_0013});
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h0050_0093, 1'b0);
        send_word(32'h0000_0013, 1'b0);
        check("last_pulse_we", 32'(imem_we_o), 1);
        check("core_held_at_pulse", 32'(core_rst_n_o), 0);
        check("ready_after_load", 32'(rx_ready_o), 0);
        tick();
        check("core_released", 32'(core_rst_n_o), 1);
        check("we_single", 32'(imem_we_o), 0);
        repeat (9) tick();
        check("cycles_before_halt", run_cycles_o, 9);
        core_halt_i = 1'b1;
        tick();
        core_halt_i = 1'b0;
        check("halt_cycles", run_cycles_o, 10);
        check("halt_done", 32'(done_o), 1);
        check("halt_core_rst", 32'(core_rst_n_o), 0);
        repeat (20) tick();
        check("hold_cycles", run_cycles_o, 10);
        check("hold_done", 32'(done_o), 1);
        do_reload();
        check("reload_cycles", run_cycles_o, 0);
        check("reload_done", 32'(done_o), 0);
        check("reload_ready", 32'(rx_ready_o), 1);

        // N=0 -> ERROR, then recover
        send_byte(8'h00); send_byte(8'h00);
        repeat (3) tick();
        check("n0_err", 32'(err_o), 1);
        check("n0_ready", 32'(rx_ready_o), 0);
        check("n0_core", 32'(core_rst_n_o), 0);
        do_reload();
        check("n0_reload_err", 32'(err_o), 0);
        check("n0_reload_ready", 32'(rx_ready_o), 1);

        // N=1025 -> ERROR
        send_byte(8'h01); send_byte(8'h04);
        tick();
        check("n1025_err", 32'(err_o), 1);
        do_reload();

        // N=1024 accepted, last write at 1023
        send_byte(8'h00); send_byte(8'h04);
        check("n1024_no_err", 32'(err_o), 0);
        for (int i = 0; i < 1024; i++) begin
            w = {16'(i) ^ 16'hA5C3, 16'(i)};
            sb_q.push_back('{10'(i), w});
            send_word(w, 1'b0);
        end
        check("n1024_last_addr", 32'(imem_addr_o), 1023);
        tick();
        check("n1024_run", 32'(core_rst_n_o), 1);
        do_reload();

        // gapped byte stream, N=1
        send_byte(8'h01); tick(); send_byte(8'h00); tick();
        sb_q.push_back('{10'd0, 32'hDDCC_BBAA});
        send_word(32'hDDCC_BBAA, 1'b1);
        check("gap_run", 32'(core_rst_n_o), 1);
        do_reload();

        // async reset mid-LOAD discards partial word
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        #2 rst = 1'b0;
        #1;
        check("arst_ready", 32'(rx_ready_o), 0);
        check("arst_addr_data", imem_wdata_o | 32'(imem_addr_o), 0);
        check("arst_flags", {28'd0, imem_we_o, core_rst_n_o, done_o, err_o}, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        sb_q.push_back('{10'd0, 32'h7856_3412});
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'h7856_3412, 1'b0);
        tick();
        check("arst_reload_run", 32'(core_rst_n_o), 1);

        // reload and halt on the same RUN edge
        repeat (3) tick();
        reload_i    = 1'b1;
        core_halt_i = 1'b1;
        tick();
        reload_i    = 1'b0;
        core_halt_i = 1'b0;
        check("race_cycles", run_cycles_o, 0);
        check("race_done", 32'(done_o), 0);
        check("race_ready", 32'(rx_ready_o), 1);
        check("race_core", 32'(core_rst_n_o), 0);

        repeat (3) tick();
        check("sb_empty", 32'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
